mul_share_arbiter: RTL and testbench

//  Shares one fully pipelined 32x32 multiplier among NUM_REQ requesters (e.g. CPU MUL/MULH path,
//  DSP helper). Arbitrates one issue per cycle, drives the multiplier operand and mode inputs,

---
 rtl/mul_share_arbiter.sv | 110 +++++++++++
 tb/tb_mul_share_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one pipelined 32x32 multiplier among NUM_REQ requesters, with in-order tagged
// result return. Define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module mul_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 3,
  parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_a_signed,
  input  logic [NUM_REQ-1:0]    req_b_signed,
  input  logic [NUM_REQ-1:0]    req_high,
  output logic                  mul_issue,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  output logic                  mul_a_signed,
  output logic                  mul_b_signed,
  output logic                  mul_type,
  input  logic [31:0]           mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  busy
);
  localparam int STAGES = LATENCY;
  localparam logic [IDW:0] NQ = (IDW+1)'(NUM_REQ);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        a_s;
    logic        b_s;
    logic        high;
  } mul_req_t;

  mul_req_t               sel, op_q;
  logic                   grant;
  logic [IDW-1:0]         win, base;
  logic [IDW:0]           cand;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][IDW-1:0] id_pipe;

`ifdef MUL_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDW-1:0] ptr;
  always_ff @(posedge clk) begin
    if (!reset_n)   ptr <= '0;
    else if (grant) ptr <= (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end
  assign base = ptr;
`endif

  // Search base, base+1, ... wrapping explicitly at NUM_REQ; held off while in reset.
  always_comb begin
    grant     = 1'b0;
    win       = '0;
    sel       = '0;
    req_ready = '0;
    cand      = '0;
    if (reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, base} + (IDW+1)'(i);
        if (cand >= NQ) cand = cand - NQ;
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!grant && cand == (IDW+1)'(j) && req_valid[j]) begin
            grant        = 1'b1;
            win          = IDW'(j);
            sel.a        = req_a[32*j +: 32];
            sel.b        = req_b[32*j +: 32];
            sel.a_s      = req_a_signed[j];
            sel.b_s      = req_b_signed[j];
            sel.high     = req_high[j];
            req_ready[j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mul_issue <= 1'b0;
      op_q      <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      mul_issue <= grant;
      if (grant) op_q <= sel;
      vld_pipe <= {vld_pipe[STAGES-1:0], grant};
      id_pipe  <= {id_pipe[STAGES-1:0], win};
      // Last stage lines up with mul_result for the tagged op.
      if (vld_pipe[STAGES]) rsp_data <= mul_result;
      for (int j = 0; j < NUM_REQ; j++)
        rsp_valid[j] <= vld_pipe[STAGES] && (id_pipe[STAGES] == IDW'(j));
    end
  end

  assign mul_a        = op_q.a;
  assign mul_b        = op_q.b;
  assign mul_a_signed = op_q.a_s;
  assign mul_b_signed = op_q.b_s;
  assign mul_type     = op_q.high;
  assign busy         = |vld_pipe;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: models the attached multiplier, keeps a per-cycle schedule of
// expected outputs, and runs directed vectors with literal expectations.
module tb_mul_share_arbiter;
  localparam int N = 2;
  localparam int L = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N-1:0]    req_valid, req_ready, req_a_signed, req_b_signed, req_high, rsp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic            mul_issue, mul_a_signed, mul_b_signed, mul_type, busy;
  logic [31:0]     mul_a, mul_b, mul_result, rsp_data;
  int checks = 0;
  int errors = 0;

  mul_share_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_a_signed(req_a_signed), .req_b_signed(req_b_signed), .req_high(req_high),
    .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed), .mul_type(mul_type),
    .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  function automatic logic [31:0] mulf(input logic [31:0] a, input logic [31:0] b,
                                       input logic as, input logic bs, input logic h);
    logic signed [65:0] ea, eb, p;
    ea = as ? {{34{a[31]}}, a} : {34'b0, a};
    eb = bs ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return h ? p[63:32] : p[31:0];
  endfunction

  // Multiplier: result of the op launched in cycle t is presented in cycle t+L.
  logic [31:0] mp [L];
  always @(posedge clk) begin
    mp[0] <= mulf(mul_a, mul_b, mul_a_signed, mul_b_signed, mul_type);
    for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
  end
  assign mul_result = mp[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Who wins given the requests and the most recent winner.
  function automatic int pick(input logic [N-1:0] v, input int lst);
`ifdef MUL_ARB_FIXED_PRIO_EN
    for (int j = 0; j < N; j++) if (v[j]) return j;
`else
    for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
`endif
    return -1;
  endfunction

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         exp_iss [32];
  logic [N-1:0] exp_v   [32];
  logic [31:0]  exp_d   [32];
  logic [31:0]  cur_d;
  int           busy_last, last;
  bit           armed = 1'b0;

  always @(negedge clk) begin
    int w, s;
    logic [N-1:0] er;
    w  = reset_n ? pick(req_valid, last) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    if (armed) begin
      s = cyc % 32;
      chk("m_ready", req_ready, er);
      chk("m_issue", mul_issue, exp_iss[s]);
      chk("m_rsp_valid", rsp_valid, exp_v[s]);
      if (exp_v[s] != '0) cur_d = exp_d[s];
      chk("m_rsp_data", rsp_data, cur_d);
      chk("m_busy", busy, cyc <= busy_last);
      exp_iss[s] = 1'b0;
      exp_v[s]   = '0;
    end
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) begin exp_iss[k] = 1'b0; exp_v[k] = '0; exp_d[k] = '0; end
      cur_d = '0; busy_last = -1; last = N - 1; armed = 1'b1;
    end else if (armed && w >= 0) begin
      exp_iss[(cyc + 1) % 32]   = 1'b1;
      exp_v[(cyc + L + 2) % 32] = er;
      exp_d[(cyc + L + 2) % 32] = mulf(req_a[32*w +: 32], req_b[32*w +: 32],
                                       req_a_signed[w], req_b_signed[w], req_high[w]);
      busy_last = cyc + L + 1;
      last = w;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic as,
                        input logic bs, input logic h, input logic [31:0] exp, input string name);
    int n;
    bit got;
    logic [N-1:0] oh;
    oh = '0; oh[r] = 1'b1;
    step();
    req_valid = '0; req_valid[r] = 1'b1;
    req_a[32*r +: 32] = a; req_b[32*r +: 32] = b;
    req_a_signed[r] = as; req_b_signed[r] = bs; req_high[r] = h;
    @(negedge clk);
    chk({name, "_ready"}, req_ready, oh);
    step();
    req_valid = '0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, "_issue"}, mul_issue, 1);
      if (rsp_valid != '0) got = 1'b1;
    end
    chk({name, "_latency"}, n, L + 2);
    chk({name, "_onehot"}, rsp_valid, oh);
    chk({name, "_data"}, rsp_data, exp);
  endtask

  initial begin
    logic [31:0] t4 [8];
    t4 = '{32'd0, 32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56};
    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    req_a_signed = '0; req_b_signed = '0; req_high = '0;
    step(); step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_issue", mul_issue, 0);
    chk("rst_mul_a", {mul_a, mul_b}, 0);
    chk("rst_modes", {mul_a_signed, mul_b_signed, mul_type}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);

    one_op(0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 32'd42, "single");
    one_op(0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, "signed_high");
    one_op(0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b1, 32'd2, "unsigned_high");
    one_op(1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'd81, "single_r1");

    // Contention from reset.
    step();
    reset_n = 1'b0; req_valid = 2'b11;
    req_a = {32'd11, 32'd10}; req_b = {32'd3, 32'd2};
    req_a_signed = '0; req_b_signed = '0; req_high = '0;
    @(negedge clk);
    chk("cont_ready_in_reset", req_ready, 0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < L + 10; k++) begin
      @(negedge clk);
`ifdef MUL_ARB_FIXED_PRIO_EN
      if (k < 8) chk("cont_ready", req_ready, 2'b01);
      if (k >= L + 2) chk("cont_rsp", rsp_valid, 2'b01);
`else
      if (k < 8) chk("cont_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= L + 2) chk("cont_rsp", rsp_valid, ((k - L - 2) % 2 == 0) ? 2'b01 : 2'b10);
`endif
      step();
      if (k == 7) req_valid = '0;
    end

    // Back-to-back from requester 1.
    for (int k = 0; k <= L + 10; k++) begin
      if (k < 8) begin
        req_valid = 2'b10; req_a[63:32] = k; req_b[63:32] = k + 1;
      end else req_valid = '0;
      @(negedge clk);
      if (k < 8) chk("b2b_ready", req_ready, 2'b10);
      if (k >= L + 2 && k <= L + 9) begin
        chk("b2b_rsp", rsp_valid, 2'b10);
        chk("b2b_data", rsp_data, t4[k-L-2]);
      end
      if (k == L + 8) chk("b2b_busy_last", busy, 1);
      if (k == L + 10) begin
        chk("b2b_busy_after", busy, 0);
        chk("b2b_rsp_after", rsp_valid, 0);
      end
      step();
    end

    // Reset with three ops in flight.
    for (int k = 0; k <= 16; k++) begin
      if (k < 3) begin req_valid = 2'b01; req_a[31:0] = k + 1; req_b[31:0] = 2; end
      else if (k == 3) begin req_valid = '0; reset_n = 1'b0; end
      else if (k == 4) reset_n = 1'b1;
      else if (k == 16) req_valid = 2'b11;
      @(negedge clk);
      if (k == 3) chk("rmid_busy_before", busy, 1);
      if (k >= 3 && k < 16) chk("rmid_no_rsp", rsp_valid, 0);
      if (k >= 4 && k < 16) chk("rmid_busy", busy, 0);
      if (k == 16) chk("rmid_ptr_zero", req_ready, 2'b01);
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // Idle gap between two requests.
    for (int k = 0; k <= L + 9; k++) begin
      req_valid = '0;
      if (k == 0) begin req_valid = 2'b01; req_a[31:0] = 5; req_b[31:0] = 5; end
      if (k == 6) begin req_valid = 2'b01; req_a[31:0] = 3; req_b[31:0] = 4; end
      @(negedge clk);
      if (k >= 2 && k <= 6) chk("gap_issue", mul_issue, 0);
      if (k >= L + 2 && k <= L + 7) chk("gap_hold", rsp_data, 25);
      if (k == L + 2) chk("gap_rsp1", rsp_valid, 2'b01);
      if (k >= L + 3 && k <= L + 7) chk("gap_quiet", rsp_valid, 0);
      if (k == L + 8) begin
        chk("gap_rsp2", rsp_valid, 2'b01);
        chk("gap_data2", rsp_data, 12);
      end
      step();
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
